down_count_timer: RTL and testbench
===================================

# down_count_timer

Programmable countdown timer: the down-counting counterpart to the free-running prescaled up counter. It loads a 12-bit value and decrements it once per prescaler tick while running. It supports pause/resume and emits a one-cycle `done` pulse on reaching zero. It feeds time-out and display logic on the board's single system clock.

## Interface
- `TICK_DIV`, default 8388608 (2^23): clk cycles per decrement; legal range 1..2^23.
- `COUNT_WIDTH`, default 12: width of `load_value` and `count`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `load_value` into `count`; abort any run.
- `load_value`  in  COUNT_WIDTH  value captured by `load`.
- `start`  in  1  begin a countdown from IDLE, or resume from PAUSED.
- `pause`  in  1  freeze the countdown while RUN.
- `count`  out  COUNT_WIDTH  current remaining count (registered).
- `running`  out  1  high while state == RUN (registered).
- `done`  out  1  one-cycle pulse on entry to EXPIRED (registered).
- `zero`  out  1  combinational, `count == 0`.

## Operation
- **State register:** IDLE, RUN, PAUSED, EXPIRED.
- **Prescaler:**
  - Counter width is ceil(log2(TICK_DIV)), minimum 1 bit.
  - Increments only in RUN and holds in every other state.
  - `tick` = RUN && prescale == TICK_DIV-1.
  - On `tick`, the prescaler wraps to 0 and `count` decrements by 1.
- **Priority per edge:** `rst` > `load` > state-specific actions.
- **Reset:** state IDLE, `count`=0, prescaler=0, `running`=0, `done`=0, so `zero`=1.
- **Load (any state):**
  - `count` <= `load_value`, prescaler <= 0, state <= IDLE, `done` <= 0.
  - Any `start`/`pause` in the same cycle is ignored.
- **IDLE:**
  - `start` with `count` != 0 goes to RUN with prescaler <= 0.
  - `start` with `count` == 0 is ignored.
  - `pause` is ignored.
- **RUN:**
  - On `tick` with `count` == 1, `count` becomes 0, state goes to EXPIRED and `done` <= 1.
  - Else, if `pause` is high, state goes to PAUSED. A `tick` in the same cycle still decrements.
  - `start` is ignored.
- **PAUSED:**
  - `count` and prescaler are held.
  - `start` returns to RUN with the prescaler preserved, so partial tick progress is kept.
  - `pause` is ignored.
- **EXPIRED:**
  - `count` holds 0.
  - `start` and `pause` are ignored; only `load` or `rst` leaves.
- **Wrap-around:** `count` never decrements below 0; there is no underflow to all-ones.
- **Arithmetic:** unsigned, COUNT_WIDTH bits.

## Timing
- **First decrement:** `start` sampled at edge E0 puts RUN in effect after E0. `count` first decrements at edge E0+TICK_DIV.
- **Run length:** for loaded value N, `count` reaches 0 and `done` rises at edge E0+N·TICK_DIV. `done` stays high exactly one cycle, and `running` falls at that same edge.
- **Pause/resume:**
  - Pause sampled at edge Ep with prescaler p (after any increment at Ep): time already elapsed is retained.
  - Resume sampled at Er: the next decrement occurs at Er+(TICK_DIV-1-p)+1.
- **TICK_DIV=1:** decrements every cycle in RUN, so `done` occurs N cycles after start.
- **Load / reset latency:** `load` and `rst` take effect at the sampling edge. Outputs reflect the new values in the following cycle.
- **Flag updates:** `running` and `done` are updated on the same edge as the state change. `zero` follows `count` combinationally.

## Test plan
All scenarios use TICK_DIV=4 unless stated.
- **Reset:**
  - Stimulus: hold `rst` 2 cycles, all other inputs 0.
  - Required: `count`=0x000, `zero`=1, `running`=0, `done`=0; `start` afterwards is ignored (count 0).
- **Basic countdown:**
  - Stimulus: load 3, then `start` at E0.
  - Required: `count` 3→2 at E0+4, 2→1 at E0+8, 1→0 at E0+12. `done`=1 for the one cycle after E0+12; `running` 1 from E0 to E0+12, then 0.
- **Pause/resume:**
  - Stimulus: load 5, `start` at E0, `pause` at E0+6, hold 10 cycles, `start` at Er.
  - Required: `count`=4 throughout the pause; next decrement to 3 at Er+2; `done` at Er+2+12.
- **Load mid-run:**
  - Stimulus: load 0x0FF, `start`, then at E0+5 load 0x000 with `start` high in the same cycle.
  - Required: `count`=0x000, state IDLE, `running`=0, no `done` pulse. A later `start` is ignored.
- **Reset mid-run and priority:**
  - Stimulus: `rst` and `load` asserted together during RUN.
  - Required: `count`=0, IDLE; `load` has no effect.
  - Stimulus: in EXPIRED, pulse `start` and `pause`.
  - Required: state stays EXPIRED, `done` does not re-pulse.
- **Full range (TICK_DIV=1):**
  - Stimulus: load 0xFFF, `start`.
  - Required: `count` decrements every cycle; `done` exactly 4095 cycles after start; `count` holds 0x000 with no wrap.

Source files
------------

// File: rtl/down_count_timer_if.sv
// Control and status bundle for the down_count_timer.
// No latency of its own: the interface only groups wires.
// No backpressure: every signal is a level or a single-cycle pulse.
interface down_count_timer_if #(
    parameter int COUNT_WIDTH = 12
);
    logic                   i_load;
    logic [COUNT_WIDTH-1:0] i_load_value;
    logic                   i_start;
    logic                   i_pause;
    logic [COUNT_WIDTH-1:0] o_count;
    logic                   o_running;
    logic                   o_done;
    logic                   o_zero;

    // Controller side: drives commands, observes timer status
    modport master (
        output i_load, i_load_value, i_start, i_pause,
        input  o_count, o_running, o_done, o_zero
    );

    // Timer side: consumes commands, reports status
    modport slave (
        input  i_load, i_load_value, i_start, i_pause,
        output o_count, o_running, o_done, o_zero
    );
endinterface

// File: rtl/down_count_timer.sv
// Programmable countdown timer: loads a value, decrements it once per prescaler tick, pulses done at zero.
// Latency: load/start act at the sampling edge; first decrement TICK_DIV edges after start is sampled.
// No backpressure: commands are sampled every cycle; pause/resume keeps partial prescaler progress.
module down_count_timer #(
    parameter int TICK_DIV    = 8388608,
    parameter int COUNT_WIDTH = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    down_count_timer_if.slave  bus
);
    // Prescaler holds values 0..TICK_DIV-1; keep at least one bit for TICK_DIV=1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [PW-1:0]          r_prescale;
    logic                   r_running;
    logic                   r_done;
    logic                   w_tick;

    // A tick only exists while running and the prescaler is at its last value.
    assign w_tick = (r_state == RUN) && (r_prescale == TICK_MAX);

    // Timer FSM: reset beats load, load beats every state-specific action.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_prescale <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else if (bus.i_load) begin
            r_state    <= IDLE;
            r_count    <= bus.i_load_value;
            r_prescale <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Starting from zero would expire instantly; treat it as a no-op.
                    if (bus.i_start && (r_count != '0)) begin
                        r_state    <= RUN;
                        r_prescale <= '0;
                        r_running  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        r_prescale <= '0;
                        if (r_count != '0) begin
                            r_count <= r_count - 1'b1;
                        end
                    end else begin
                        r_prescale <= r_prescale + PW'(1);
                    end
                    // Expiry wins over pause; a pause coinciding with a tick still decrements.
                    if (w_tick && (r_count == COUNT_WIDTH'(1))) begin
                        r_state   <= EXPIRED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (bus.i_pause) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end
                end
                PAUSED: begin
                    // Prescaler is left untouched so the partial tick carries over.
                    if (bus.i_start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                EXPIRED: begin
                    // Parked at zero until load or reset.
                    r_state <= EXPIRED;
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_count   = r_count;
    assign bus.o_running = r_running;
    assign bus.o_done    = r_done;
    assign bus.o_zero    = (r_count == '0);
endmodule

// File: tb/tb_down_count_timer.sv
// Directed bench for down_count_timer: TICK_DIV=4 instance for most scenarios, TICK_DIV=1 for full range.
module tb_down_count_timer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    down_count_timer_if #(.COUNT_WIDTH(12)) a_if ();
    down_count_timer_if #(.COUNT_WIDTH(12)) b_if ();

    down_count_timer #(.TICK_DIV(4), .COUNT_WIDTH(12)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (a_if.slave)
    );

    down_count_timer #(.TICK_DIV(1), .COUNT_WIDTH(12)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [11:0] exp_cnt,
                         input logic exp_run, input logic exp_done);
        checks++;
        if (a_if.o_count !== exp_cnt || a_if.o_running !== exp_run ||
            a_if.o_done !== exp_done || a_if.o_zero !== (exp_cnt == 12'h000)) begin
            errors++;
            $display("FAIL %s: got count=%h run=%b done=%b zero=%b, expected count=%h run=%b done=%b zero=%b",
                     name, a_if.o_count, a_if.o_running, a_if.o_done, a_if.o_zero,
                     exp_cnt, exp_run, exp_done, (exp_cnt == 12'h000));
        end
    endtask

    task automatic load_a(input logic [11:0] v);
        a_if.i_load = 1'b1;
        a_if.i_load_value = v;
        cyc();
        a_if.i_load = 1'b0;
    endtask

    task automatic start_a();
        a_if.i_start = 1'b1;
        cyc();
        a_if.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_a("reset_state", 12'h000, 1'b0, 1'b0);
        checks++;
        if (b_if.o_count !== 12'h000 || b_if.o_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_b: got count=%h zero=%b, expected count=000 zero=1",
                     b_if.o_count, b_if.o_zero);
        end
        start_a();
        chk_a("reset_start_ignored", 12'h000, 1'b0, 1'b0);
        cyc();
        chk_a("reset_start_ignored_later", 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_basic_countdown();
        load_a(12'd3);
        chk_a("basic_loaded", 12'd3, 1'b0, 1'b0);
        start_a();  // E0
        chk_a("basic_e0", 12'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            logic [11:0] ec;
            cyc();
            ec = 12'(3 - k / 4);
            chk_a($sformatf("basic_e0+%0d", k), ec, (k < 12), (k == 12));
        end
        cyc();
        chk_a("basic_done_one_cycle", 12'd0, 1'b0, 1'b0);
    endtask

    task automatic test_pause_resume();
        load_a(12'd5);
        start_a();  // E0
        for (int k = 1; k <= 5; k++) cyc();
        chk_a("pause_before", 12'd4, 1'b1, 1'b0);
        a_if.i_pause = 1'b1;
        cyc();      // E0+6, prescaler now 2
        a_if.i_pause = 1'b0;
        chk_a("pause_entered", 12'd4, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            // pause pulsed again while paused must be ignored
            a_if.i_pause = (k == 3);
            cyc();
            chk_a($sformatf("pause_hold_%0d", k), 12'd4, 1'b0, 1'b0);
        end
        a_if.i_pause = 1'b0;
        start_a();  // Er
        chk_a("resume_er", 12'd4, 1'b1, 1'b0);
        cyc();
        chk_a("resume_er+1", 12'd4, 1'b1, 1'b0);
        cyc();
        chk_a("resume_er+2", 12'd3, 1'b1, 1'b0);
        for (int k = 3; k <= 13; k++) cyc();
        chk_a("resume_er+13", 12'd1, 1'b1, 1'b0);
        cyc();
        chk_a("resume_done_er+14", 12'd0, 1'b0, 1'b1);
        cyc();
        chk_a("resume_after_done", 12'd0, 1'b0, 1'b0);
    endtask

    task automatic test_load_mid_run();
        load_a(12'h0FF);
        start_a();  // E0
        for (int k = 1; k <= 4; k++) cyc();
        chk_a("midload_e0+4", 12'h0FE, 1'b1, 1'b0);
        a_if.i_load = 1'b1;
        a_if.i_load_value = 12'h000;
        a_if.i_start = 1'b1;
        cyc();      // E0+5
        a_if.i_load = 1'b0;
        a_if.i_start = 1'b0;
        chk_a("midload_cleared", 12'h000, 1'b0, 1'b0);
        start_a();
        chk_a("midload_start_ignored", 12'h000, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk_a($sformatf("midload_no_done_%0d", k), 12'h000, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_priority();
        load_a(12'd7);
        start_a();
        cyc();
        cyc();
        rst = 1'b1;
        a_if.i_load = 1'b1;
        a_if.i_load_value = 12'h123;
        cyc();
        rst = 1'b0;
        a_if.i_load = 1'b0;
        chk_a("rst_beats_load", 12'h000, 1'b0, 1'b0);
        cyc();
        chk_a("rst_beats_load_hold", 12'h000, 1'b0, 1'b0);

        // Back-to-back: load+start immediately, run to EXPIRED
        load_a(12'd1);
        start_a();
        for (int k = 1; k <= 3; k++) cyc();
        chk_a("exp_before", 12'd1, 1'b1, 1'b0);
        cyc();
        chk_a("exp_done", 12'd0, 1'b0, 1'b1);
        a_if.i_start = 1'b1;
        a_if.i_pause = 1'b1;
        cyc();
        chk_a("exp_start_pause_1", 12'd0, 1'b0, 1'b0);
        a_if.i_pause = 1'b0;
        cyc();
        a_if.i_start = 1'b0;
        chk_a("exp_start_pause_2", 12'd0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk_a($sformatf("exp_no_repulse_%0d", k), 12'd0, 1'b0, 1'b0);
        end
        // Load leaves EXPIRED and a fresh run works
        load_a(12'd2);
        chk_a("exp_reload", 12'd2, 1'b0, 1'b0);
        start_a();
        for (int k = 1; k <= 4; k++) cyc();
        chk_a("exp_reload_run", 12'd1, 1'b1, 1'b0);
    endtask

    task automatic test_full_range();
        b_if.i_load = 1'b1;
        b_if.i_load_value = 12'hFFF;
        cyc();
        b_if.i_load = 1'b0;
        b_if.i_start = 1'b1;
        cyc();      // E0
        b_if.i_start = 1'b0;
        checks++;
        if (b_if.o_count !== 12'hFFF || b_if.o_running !== 1'b1) begin
            errors++;
            $display("FAIL full_e0: got count=%h run=%b, expected count=fff run=1",
                     b_if.o_count, b_if.o_running);
        end
        for (int k = 1; k <= 4095; k++) begin
            logic [11:0] ec;
            cyc();
            ec = 12'(4095 - k);
            checks++;
            if (b_if.o_count !== ec || b_if.o_done !== (k == 4095) ||
                b_if.o_running !== (k < 4095)) begin
                errors++;
                $display("FAIL full_e0+%0d: got count=%h done=%b run=%b, expected count=%h done=%b run=%b",
                         k, b_if.o_count, b_if.o_done, b_if.o_running,
                         ec, (k == 4095), (k < 4095));
            end
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (b_if.o_count !== 12'h000 || b_if.o_done !== 1'b0 || b_if.o_zero !== 1'b1) begin
                errors++;
                $display("FAIL full_no_wrap_%0d: got count=%h done=%b zero=%b, expected count=000 done=0 zero=1",
                         k, b_if.o_count, b_if.o_done, b_if.o_zero);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_if.i_load = 1'b0;
        a_if.i_load_value = '0;
        a_if.i_start = 1'b0;
        a_if.i_pause = 1'b0;
        b_if.i_load = 1'b0;
        b_if.i_load_value = '0;
        b_if.i_start = 1'b0;
        b_if.i_pause = 1'b0;
        #2;
        test_reset();
        test_basic_countdown();
        test_pause_resume();
        test_load_mid_run();
        test_reset_priority();
        test_full_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
